// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
// button_bank : multi-channel debounced buttons with press counters/repeat
// Revision    : 1.0
// ============================================================================
module button_bank #(
   parameter int N_BTN     = 4,
   parameter int SAT_MAX   = 25,
   parameter int CNT_W     = 16,
   parameter int REP_DELAY = 500,
   parameter int REP_RATE  = 100,
   parameter int WRAP      = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ce,
   input  logic [N_BTN-1:0]       btn_in,
   input  logic [N_BTN-1:0]       rep_en,
   input  logic [N_BTN-1:0]       clr,
   output logic [N_BTN-1:0]       pressed,
   output logic [N_BTN-1:0]       press_p,
   output logic [N_BTN-1:0]       release_p,
   output logic [N_BTN-1:0]       repeat_p,
   output logic [N_BTN*CNT_W-1:0] count
);

   localparam int SAT_W   = $clog2(SAT_MAX + 1);
   localparam int TMR_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [SAT_W-1:0] C_SAT_FULL  = SAT_W'(SAT_MAX);
   localparam logic [TMR_W-1:0] C_REP_DELAY = TMR_W'(REP_DELAY);
   localparam logic [TMR_W-1:0] C_REP_RATE  = TMR_W'(REP_RATE);
   localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic             sync1_q, btn_s_q;
      logic [SAT_W-1:0] sat_q, sat_d;
      state_t           state_q, state_d;
      logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
      logic             pressed_q, pressed_d;
      logic             press_q, press_d, rel_q, rel_d, rep_q, rep_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             bump;

      assign tmr_inc = tmr_q + 1'b1;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            sat_q     <= '0;
            state_q   <= IDLE;
            tmr_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            rep_q     <= 1'b0;
            cnt_q     <= '0;
         end else begin
            sync1_q   <= btn_in[i];
            btn_s_q   <= sync1_q;
            sat_q     <= sat_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            rep_q     <= rep_d;
            cnt_q     <= cnt_d;
         end
      end

      // FSM decisions use the pre-update integrator value.
      always_comb begin
         sat_d     = sat_q;
         state_d   = state_q;
         tmr_d     = tmr_q;
         pressed_d = pressed_q;
         press_d   = 1'b0;
         rel_d     = 1'b0;
         rep_d     = 1'b0;
         bump      = 1'b0;
         if (ce) begin
            if (btn_s_q && (sat_q != C_SAT_FULL)) begin
               sat_d = sat_q + 1'b1;
            end else if (!btn_s_q && (sat_q != '0)) begin
               sat_d = sat_q - 1'b1;
            end
            case (state_q)
               IDLE: begin
                  if (sat_q == C_SAT_FULL) begin
                     state_d   = HELD;
                     pressed_d = 1'b1;
                     press_d   = 1'b1;
                     bump      = 1'b1;
                     tmr_d     = '0;
                  end
               end
               HELD, REPEAT: begin
                  if (sat_q == '0) begin
                     state_d   = IDLE;
                     pressed_d = 1'b0;
                     rel_d     = 1'b1;
                     tmr_d     = '0;
                  end else if (rep_en[i]) begin
                     if (tmr_inc == ((state_q == HELD) ? C_REP_DELAY : C_REP_RATE)) begin
                        state_d = REPEAT;
                        rep_d   = 1'b1;
                        bump    = 1'b1;
                        tmr_d   = '0;
                     end else begin
                        tmr_d = tmr_inc;
                     end
                  end else begin
                     tmr_d = '0;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end

      always_comb begin
         cnt_d = cnt_q;
         if (clr[i]) begin
            cnt_d = '0;
         end else if (bump) begin
            if ((WRAP == 0) && (cnt_q == C_CNT_MAX)) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      assign pressed[i]                = pressed_q;
      assign press_p[i]                = press_q;
      assign release_p[i]              = rel_q;
      assign repeat_p[i]               = rep_q;
      assign count[i*CNT_W +: CNT_W]   = cnt_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
// tb_button_bank : randomized-timing bench with a behavioural button model
// Revision       : 1.0
// ============================================================================
module tb_button_bank;

   localparam int NB = 4;
   localparam int SAT = 25;
   localparam int RD = 500;
   localparam int RR = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b0;
   logic [NB-1:0] btn_in = '0, rep_en = '0, clr = '0;

   logic [NB-1:0] pr, pp, rp, tp;
   logic [NB*16-1:0] cnt;
   logic [NB-1:0] pr_w, pp_w, rp_w, tp_w;
   logic [NB*4-1:0] cnt_w;
   logic [NB-1:0] pr_s, pp_s, rp_s, tp_s;
   logic [NB*4-1:0] cnt_s;

   button_bank #(.N_BTN(NB), .SAT_MAX(SAT), .CNT_W(16), .REP_DELAY(RD), .REP_RATE(RR), .WRAP(1)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .btn_in(btn_in), .rep_en(rep_en), .clr(clr),
      .pressed(pr), .press_p(pp), .release_p(rp), .repeat_p(tp), .count(cnt));
   button_bank #(.N_BTN(NB), .SAT_MAX(SAT), .CNT_W(4), .REP_DELAY(RD), .REP_RATE(RR), .WRAP(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .ce(ce), .btn_in(btn_in), .rep_en(rep_en), .clr(clr),
      .pressed(pr_w), .press_p(pp_w), .release_p(rp_w), .repeat_p(tp_w), .count(cnt_w));
   button_bank #(.N_BTN(NB), .SAT_MAX(SAT), .CNT_W(4), .REP_DELAY(RD), .REP_RATE(RR), .WRAP(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .ce(ce), .btn_in(btn_in), .rep_en(rep_en), .clr(clr),
      .pressed(pr_s), .press_p(pp_s), .release_p(rp_s), .repeat_p(tp_s), .count(cnt_s));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: integer debounce level, "is down" flag and a count of
   // ce ticks since the last reported event.
   int m_s1[NB], m_s2[NB], m_sat[NB], m_tick[NB], m_reps[NB];
   int m_c16[NB], m_cw[NB], m_cs[NB];
   bit m_down[NB], m_press[NB], m_rel[NB], m_rep[NB];

   always @(posedge clk or negedge rst_n) begin
      for (int c = 0; c < NB; c++) begin
         if (!rst_n) begin
            m_s1[c] = 0; m_s2[c] = 0; m_sat[c] = 0; m_tick[c] = 0; m_reps[c] = 0;
            m_c16[c] = 0; m_cw[c] = 0; m_cs[c] = 0;
            m_down[c] = 0; m_press[c] = 0; m_rel[c] = 0; m_rep[c] = 0;
         end else begin
            automatic int  prev = m_sat[c];
            automatic bit  event_cnt = 0;
            m_press[c] = 0; m_rel[c] = 0; m_rep[c] = 0;
            if (ce) begin
               m_sat[c] = m_s2[c] ? ((prev < SAT) ? prev + 1 : SAT) : ((prev > 0) ? prev - 1 : 0);
               if (!m_down[c]) begin
                  if (prev == SAT) begin
                     m_down[c] = 1; m_press[c] = 1; event_cnt = 1; m_tick[c] = 0; m_reps[c] = 0;
                  end
               end else if (prev == 0) begin
                  m_down[c] = 0; m_rel[c] = 1;
               end else if (rep_en[c]) begin
                  m_tick[c]++;
                  if (m_tick[c] == ((m_reps[c] == 0) ? RD : RR)) begin
                     m_rep[c] = 1; event_cnt = 1; m_tick[c] = 0; m_reps[c]++;
                  end
               end else begin
                  m_tick[c] = 0;
               end
            end
            if (clr[c]) begin
               m_c16[c] = 0; m_cw[c] = 0; m_cs[c] = 0;
            end else if (event_cnt) begin
               m_c16[c] = (m_c16[c] + 1) % 65536;
               m_cw[c]  = (m_cw[c] + 1) % 16;
               m_cs[c]  = (m_cs[c] < 15) ? m_cs[c] + 1 : 15;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_in[c];
         end
      end
   end

   // Cycle-level monitor: tally DUT pulses and cycles where any DUT deviates from the model.
   int n_press[NB], n_rel[NB], n_rep[NB];
   int mism_cycles = 0;
   initial for (int c = 0; c < NB; c++) begin n_press[c] = 0; n_rel[c] = 0; n_rep[c] = 0; end

   always @(negedge clk) begin
      automatic bit bad = 0;
      for (int c = 0; c < NB; c++) begin
         n_press[c] += int'(pp[c]);
         n_rel[c]   += int'(rp[c]);
         n_rep[c]   += int'(tp[c]);
         if (pr[c] !== m_down[c] || pp[c] !== m_press[c] || rp[c] !== m_rel[c] || tp[c] !== m_rep[c]) bad = 1;
         if (pr_w[c] !== m_down[c] || pp_w[c] !== m_press[c] || tp_w[c] !== m_rep[c]) bad = 1;
         if (pr_s[c] !== m_down[c] || pp_s[c] !== m_press[c] || rp_s[c] !== m_rel[c]) bad = 1;
         if (int'(cnt[c*16 +: 16]) != m_c16[c] || int'(cnt_w[c*4 +: 4]) != m_cw[c]
             || int'(cnt_s[c*4 +: 4]) != m_cs[c]) bad = 1;
      end
      if (bad) mism_cycles++;
   end

   task automatic ce_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         ce = 1'b1;
         @(negedge clk);
         ce = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (pr !== '0 || pp !== '0 || rp !== '0 || tp !== '0) begin
         errors++; $display("FAIL reset_flags: got %b/%b/%b/%b want 0", pr, pp, rp, tp);
      end
      checks++;
      if (cnt !== '0 || cnt_w !== '0 || cnt_s !== '0) begin
         errors++; $display("FAIL reset_count: got %h want 0", cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_press();
      btn_in[0] = 1'b1;
      ce_ticks(40);
      checks++;
      if (pr[0] !== 1'b1) begin errors++; $display("FAIL t1_pressed: got %b want 1", pr[0]); end
      btn_in[0] = 1'b0;
      ce_ticks(40);
      checks++;
      if (n_press[0] != 1 || n_rel[0] != 1) begin
         errors++; $display("FAIL t1_pulses: press %0d rel %0d want 1 1", n_press[0], n_rel[0]);
      end
      checks++;
      if (cnt[15:0] !== 16'd1 || cnt[63:16] !== '0) begin
         errors++; $display("FAIL t1_count: got %h want 0000000000000001", cnt);
      end
      checks++;
      if (mism_cycles != 0) begin errors++; $display("FAIL t1_model: %0d mismatching cycles want 0", mism_cycles); end
   endtask

   task automatic test_bounce();
      for (int r = 0; r < 3; r++) begin
         btn_in[1] = 1'b1; ce_ticks(10);
         btn_in[1] = 1'b0; ce_ticks(5);
      end
      ce_ticks(20);
      checks++;
      if (n_press[1] != 0 || cnt[31:16] !== 16'd0 || pr[1] !== 1'b0) begin
         errors++; $display("FAIL t2_bounce: presses %0d count %0d want 0 0", n_press[1], cnt[31:16]);
      end
      checks++;
      if (mism_cycles != 0) begin errors++; $display("FAIL t2_model: %0d mismatching cycles want 0", mism_cycles); end
   endtask

   task automatic test_repeat();
      rep_en[2] = 1'b1;
      btn_in[2] = 1'b1;
      ce_ticks(26 + RD + 3*RR + 50);
      btn_in[2] = 1'b0;
      ce_ticks(30);
      checks++;
      if (n_press[2] != 1 || n_rep[2] != 4 || n_rel[2] != 1) begin
         errors++; $display("FAIL t3_pulses: press %0d rep %0d rel %0d want 1 4 1", n_press[2], n_rep[2], n_rel[2]);
      end
      checks++;
      if (cnt[47:32] !== 16'd5) begin errors++; $display("FAIL t3_count: got %0d want 5", cnt[47:32]); end
      ce_ticks(150);
      checks++;
      if (n_rep[2] != 4) begin errors++; $display("FAIL t3_after_release: rep %0d want 4", n_rep[2]); end
      rep_en[2] = 1'b0;
      checks++;
      if (mism_cycles != 0) begin errors++; $display("FAIL t3_model: %0d mismatching cycles want 0", mism_cycles); end
   endtask

   task automatic test_wrap();
      for (int p = 0; p < 17; p++) begin
         btn_in[3] = 1'b1; ce_ticks(28 + $urandom_range(0, 5));
         btn_in[3] = 1'b0; ce_ticks(28 + $urandom_range(0, 5));
      end
      checks++;
      if (cnt_w[15:12] !== 4'd1) begin errors++; $display("FAIL t4_wrap: got %0d want 1", cnt_w[15:12]); end
      checks++;
      if (cnt_s[15:12] !== 4'd15) begin errors++; $display("FAIL t4_sat: got %0d want 15", cnt_s[15:12]); end
      checks++;
      if (cnt[63:48] !== 16'd17 || n_press[3] != 17) begin
         errors++; $display("FAIL t4_wide: got %0d presses %0d want 17 17", cnt[63:48], n_press[3]);
      end
      checks++;
      if (mism_cycles != 0) begin errors++; $display("FAIL t4_model: %0d mismatching cycles want 0", mism_cycles); end
   endtask

   task automatic test_clr_same_edge();
      bit fired = 0;
      btn_in[3] = 1'b1;
      for (int k = 0; k < 60 && !fired; k++) begin
         if (m_sat[3] == SAT && !m_down[3]) begin clr[3] = 1'b1; fired = 1; end
         ce = 1'b1;
         @(negedge clk);
         ce = 1'b0;
         clr[3] = 1'b0;
         if (fired) begin
            checks++;
            if (pp[3] !== 1'b1 || pp_w[3] !== 1'b1) begin
               errors++; $display("FAIL t5_press_pulse: got %b want 1", pp[3]);
            end
            checks++;
            if (cnt[63:48] !== 16'd0 || cnt_w[15:12] !== 4'd0 || cnt_s[15:12] !== 4'd0) begin
               errors++; $display("FAIL t5_clr_wins: got %0d want 0", cnt[63:48]);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (!fired) begin errors++; $display("FAIL t5_no_press: press point not reached within 60 ce"); end
      btn_in[3] = 1'b0; ce_ticks(30);
      btn_in[3] = 1'b1; ce_ticks(30);
      btn_in[3] = 1'b0; ce_ticks(30);
      checks++;
      if (cnt[63:48] !== 16'd1 || cnt_w[15:12] !== 4'd1 || cnt_s[15:12] !== 4'd1) begin
         errors++; $display("FAIL t5_next_press: got %0d want 1", cnt[63:48]);
      end
      checks++;
      if (mism_cycles != 0) begin errors++; $display("FAIL t5_model: %0d mismatching cycles want 0", mism_cycles); end
   endtask

   task automatic test_async_reset();
      int base_rep = n_rep[0];
      int got = -1;
      rep_en[0] = 1'b1;
      btn_in[0] = 1'b1;
      ce_ticks(26 + RD + 50);
      checks++;
      if (n_rep[0] - base_rep != 1 || pr[0] !== 1'b1) begin
         errors++; $display("FAIL t6_in_repeat: reps %0d pressed %b want 1 1", n_rep[0] - base_rep, pr[0]);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (pr !== '0 || pp !== '0 || rp !== '0 || tp !== '0 || cnt !== '0 || cnt_w !== '0 || cnt_s !== '0) begin
         errors++; $display("FAIL t6_async_clear: pressed %b count %h want 0", pr, cnt);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      for (int k = 1; k <= 40 && got < 0; k++) begin
         ce = 1'b1;
         @(negedge clk);
         ce = 1'b0;
         if (pp[0] === 1'b1) got = k;
         @(negedge clk);
      end
      checks++;
      if (got != SAT + 1) begin errors++; $display("FAIL t6_fresh_press: ce ticks %0d want %0d", got, SAT + 1); end
      checks++;
      if (cnt[15:0] !== 16'd1) begin errors++; $display("FAIL t6_count: got %0d want 1", cnt[15:0]); end
      btn_in[0] = 1'b0;
      rep_en[0] = 1'b0;
      ce_ticks(30);
      checks++;
      if (mism_cycles != 0) begin errors++; $display("FAIL t6_model: %0d mismatching cycles want 0", mism_cycles); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_repeat();
      test_wrap();
      test_clr_same_edge();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
